rr_onehot_arbiter: RTL
======================

// Module: rr_onehot_arbiter
// PURPOSE
//  Round-robin arbiter sharing one resource among N requesters. Issues a
//  registered one-hot grant, holds it until the owner releases it or a hold
//  timeout expires, then rotates priority. An internal exactly-one-bit check
//  on the grant vector sets a sticky error flag.
// PARAMETERS
//  N        4    number of requesters; minimum 2
//  IDW      2    width of grant_id; must satisfy 2**IDW >= N
//  MAX_HOLD 16   max cycles a grant is held before forced revoke; minimum 1
//  CW       5    hold-counter width; must satisfy 2**CW > MAX_HOLD
// PORTS
//  clk        in   1    clock; all state changes on the rising edge
//  rst_n      in   1    asynchronous active-low reset
//  req        in   N    request vector; bit i set = requester i wants the resource
//  release    in   1    owner done; sampled only in BUSY
//  grant      out  N    one-hot grant; all zero when the resource is free
//  grant_vld  out  1    equals |grant
//  grant_id   out  IDW  index of the granted requester; 0 when no grant
//  timeout    out  1    one-cycle pulse on a forced revoke
//  onehot_err out  1    sticky; set when grant is nonzero and not one-hot
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, grant=0, grant_vld=0, grant_id=0,
//   timeout=0, onehot_err=0, last=N-1 (bit 0 has top priority first), hold_cnt=0.
//  All outputs are registered. There is no combinational path from req to grant.
//  States:
//   IDLE: if |req at an edge, grant winner, go to BUSY, hold_cnt=1. Else stay.
//   BUSY: go to IDLE, clear grant, set last=grant_id if any of:
//    a) release=1
//    b) req[grant_id]=0 (owner dropped; same as a release)
//    c) hold_cnt==MAX_HOLD (forced revoke; timeout=1 for that one cycle)
//   Otherwise hold the grant and increment hold_cnt.
//  Winner: first set bit of req scanning last+1, last+2, ... (mod N).
//   The scan wraps from N-1 to 0.
//  Latency: req rises before edge k in IDLE -> grant valid after edge k.
//  Release sampled at edge k -> grant is 0 after edge k.
//  IDLE lasts at least one cycle between grants: back-to-back grants are
//   spaced by exactly 1 idle cycle.
//  Simultaneous release and timeout: treated as a release; timeout is not pulsed.
//  release in IDLE: ignored.
//  req changes while BUSY: ignored, except the owner bit (rule b).
//  onehot_err: set at any edge where grant!=0 and grant&(grant-1)!=0.
//   Cleared only by reset. Must never set in correct operation.
//  Reset mid-grant: grant drops immediately (async). Priority returns to bit 0.
// TESTING
//  1 Reset; req=4'b1111; never release -> grants rotate 0,1,2,3,0.
//    Each grant lasts 16 cycles, each ends with a timeout pulse, 1 idle cycle between.
//  2 req=4'b0101; release 3 cycles after each grant -> grant 0001, 0100, 0001.
//    grant_id 0, 2, 0. timeout stays 0.
//  3 req=4'b1000 only, after last=3 -> wrap scan; grant 1000, grant_id=3.
//  4 Grant to 1; drop req[1] without release -> grant=0 next edge.
//    Next winner is 2 if req[2]=1.
//  5 release and hold_cnt==MAX_HOLD at the same edge -> grant clears, timeout=0.
//  6 Assert rst_n=0 mid-BUSY -> grant=0 without a clock edge.
//    After reset, req=4'b1010 -> grant 0010. onehot_err=0 throughout all tests.

Source files
------------

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, hold timeout and
// a sticky flag that trips if the grant vector is ever multi-hot.
module rr_onehot_arbiter #(
    parameter int N        = 4,
    parameter int IDW      = 2,
    parameter int MAX_HOLD = 16,
    parameter int CW       = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   i_req,
    input  logic           i_release,
    output logic [N-1:0]   o_grant,
    output logic           o_grant_vld,
    output logic [IDW-1:0] o_grant_id,
    output logic           o_timeout,
    output logic           o_onehot_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [N-1:0]   LP_ONE      = {{(N-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  LP_CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  LP_CNT_MAX  = CW'(MAX_HOLD);
    localparam logic [IDW-1:0] LP_LAST_RST = IDW'(N - 1);

    // True when more than one bit of v is set.
    function automatic logic multi_hot(input logic [N-1:0] v);
        return (v != '0) && ((v & (v - LP_ONE)) != '0);
    endfunction

    state_t         r_state;
    logic [N-1:0]   r_grant;
    logic           r_grant_vld;
    logic [IDW-1:0] r_grant_id;
    logic [IDW-1:0] r_last;
    logic [CW-1:0]  r_hold_cnt;
    logic           r_timeout;
    logic           r_onehot_err;

    state_t         w_state_nxt;
    logic [N-1:0]   w_grant_nxt;
    logic [IDW-1:0] w_id_nxt;
    logic [IDW-1:0] w_last_nxt;
    logic [CW-1:0]  w_cnt_nxt;
    logic           w_timeout_nxt;
    logic [IDW-1:0] w_win_id;
    logic           w_win_found;
    logic [N-1:0]   w_win_grant;

    // Priority scan starting just after the previous owner, wrapping at N-1.
    always_comb begin
        int v_idx;
        w_win_id    = '0;
        w_win_found = 1'b0;
        v_idx       = 0;
        for (int i = 1; i <= N; i++) begin
            v_idx = (int'(r_last) + i) % N;
            if (!w_win_found && i_req[v_idx]) begin
                w_win_found = 1'b1;
                w_win_id    = v_idx[IDW-1:0];
            end else begin
                w_win_found = w_win_found;
            end
        end
        w_win_grant = LP_ONE << w_win_id;
    end

    // Next-state logic; release and owner-drop take precedence over the timeout.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_id_nxt      = r_grant_id;
        w_last_nxt    = r_last;
        w_cnt_nxt     = r_hold_cnt;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_win_found) begin
                    w_state_nxt = ST_BUSY;
                    w_grant_nxt = w_win_grant;
                    w_id_nxt    = w_win_id;
                    w_cnt_nxt   = LP_CNT_ONE;
                end else begin
                    w_grant_nxt = '0;
                end
            end
            ST_BUSY: begin
                if (i_release || !i_req[r_grant_id]) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_id_nxt    = '0;
                    w_last_nxt  = r_grant_id;
                    w_cnt_nxt   = '0;
                end else if (r_hold_cnt == LP_CNT_MAX) begin
                    w_state_nxt   = ST_IDLE;
                    w_grant_nxt   = '0;
                    w_id_nxt      = '0;
                    w_last_nxt    = r_grant_id;
                    w_cnt_nxt     = '0;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_hold_cnt + LP_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
                w_id_nxt    = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_grant_vld  <= 1'b0;
            r_grant_id   <= '0;
            r_last       <= LP_LAST_RST;
            r_hold_cnt   <= '0;
            r_timeout    <= 1'b0;
            r_onehot_err <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_grant_vld  <= |w_grant_nxt;
            r_grant_id   <= w_id_nxt;
            r_last       <= w_last_nxt;
            r_hold_cnt   <= w_cnt_nxt;
            r_timeout    <= w_timeout_nxt;
            r_onehot_err <= r_onehot_err | multi_hot(r_grant);
        end
    end

    assign o_grant      = r_grant;
    assign o_grant_vld  = r_grant_vld;
    assign o_grant_id   = r_grant_id;
    assign o_timeout    = r_timeout;
    assign o_onehot_err = r_onehot_err;

endmodule
